// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and counter sizing for the bit-serial adder.
// Optional feature macro: SERIAL_ADDER_SUB_EN (subtract support in serial_adder_ctrl).
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/ready request bus plus result bus of the bit-serial adder.
// Ports: start, a, b, sub (only with SERIAL_ADDER_SUB_EN) requester->adder;
//        ready, busy, done, sum, carry_out, overflow adder->requester.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub;
  modport master(output start, a, b, sub, input ready, busy, done, sum, carry_out, overflow);
  modport slave(input start, a, b, sub, output ready, busy, done, sum, carry_out, overflow);
`else
  modport master(output start, a, b, input ready, busy, done, sum, carry_out, overflow);
  modport slave(input start, a, b, output ready, busy, done, sum, carry_out, overflow);
`endif
  logic ready;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic carry_out;
  logic overflow;
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// serial_adder_ctrl_full_adder: 1-bit half-adder cell and the full adder built from two of them.
// Ports: i_a, i_b, i_c (carry in) -> o_s (sum), o_c (carry out).
module half_adder_1_bit (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module full_adder_1_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_s0, w_c0, w_c1;
  half_adder_1_bit u_ha0 (.i_a(i_a), .i_b(i_b), .o_s(w_s0), .o_c(w_c0));
  half_adder_1_bit u_ha1 (.i_a(w_s0), .i_b(i_c), .o_s(o_s), .o_c(w_c1));
  assign o_c = w_c0 | w_c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder reusing one full-adder cell, LSB first.
// Ports: clk, reset (async, active-high), bus (serial_adder_ctrl_if.slave).
// Optional feature macro: SERIAL_ADDER_SUB_EN adds bus.sub for A-B via inverted B and carry-in 1.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0] r_cnt;
  logic r_c, r_co, r_ov;
  logic w_s, w_c, w_last, w_sub;
`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = bus.sub;
`else
  assign w_sub = 1'b0;
`endif
  full_adder_1_bit u_fa (.i_a(r_a[0]), .i_b(r_b[0]), .i_c(r_c), .o_s(w_s), .o_c(w_c));
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)  ? (bus.start ? SHIFT : IDLE) :
             (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
      r_cnt <= '0;
      r_c   <= 1'b0;
      r_co  <= 1'b0;
      r_ov  <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_a   <= bus.a;
      r_b   <= w_sub ? ~bus.b : bus.b;
      r_c   <= w_sub;
      r_cnt <= '0;
      r_sum <= '0;
    end else if (r_state == SHIFT) begin
      r_sum <= {w_s, r_sum[WIDTH-1:1]};
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_c;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_co <= w_c;
        // r_c still holds the carry into the MSB during the final bit
        r_ov <= r_c ^ w_c;
      end
    end
  assign bus.ready     = r_state == IDLE;
  assign bus.busy      = r_state == SHIFT;
  assign bus.done      = r_state == DONE;
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_co;
  assign bus.overflow  = r_ov;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of serial_adder_ctrl against an arithmetic model.
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // returns {overflow, carry_out, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] bb;
    logic [W:0] t;
    logic ov;
    bb = s ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    ov = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return {ov, t};
  endfunction
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is, input int poke);
    int n;
    logic [W+1:0] m;
    m = model(ia, ib, is);
    bus.a = ia;
    bus.b = ib;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = is;
`endif
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("accept_busy", bus.busy, 1);
    chk("accept_ready", bus.ready, 0);
    n = 0;
    while (n < W + 4 && !bus.done) begin
      if (n == poke) begin
        bus.a = 'hAA;
        bus.start = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n++;
    end
    chk("latency", n, W);
    chk("sum", bus.sum, m[W-1:0]);
    chk("carry_out", bus.carry_out, m[W]);
    chk("overflow", bus.overflow, m[W+1]);
    @(posedge clk);
    #1;
    chk("done_single", bus.done, 0);
    chk("ready_back", bus.ready, 1);
    chk("sum_held", bus.sum, m[W-1:0]);
  endtask
  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    logic rs;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_co", bus.carry_out, 0);
    chk("rst_ov", bus.overflow, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_op(8'h3C, 8'h0F, 1'b0, -1);
    do_op(8'hFF, 8'h01, 1'b0, -1);
    do_op(8'h7F, 8'h01, 1'b0, -1);
    do_op(8'h10, 8'h20, 1'b0, 3);
    do_op(8'hFF, 8'h01, 1'b0, -1);
    bus.a = 8'hFF;
    bus.b = 8'h00;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_ready", bus.ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_sum", bus.sum, 0);
    chk("abort_co", bus.carry_out, 0);
    chk("abort_ov", bus.overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    do_op(8'h01, 8'h01, 1'b0, -1);
`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, -1);
    do_op(8'h80, 8'h01, 1'b1, -1);
`endif
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rs, -1);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
